// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler
//   Round-robin scan sequencer for a pipelined SPI ADC receiver. Each frame
//   builds an 8-bit config word for the next enabled channel and pulses it into
//   the receiver once every SAMPLE_PERIOD clocks. The result returned during
//   frame k belongs to the config sent in frame k-1, and it is published
//   together with that channel.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_enable           run scan; when low, the current frame finishes and the block idles
//   i_ch_mask[7:0]     channel enables, bit n = channel n
//   i_uni              UNI bit of the config word
//   i_err_clr          clears o_timeout_err (a timeout in the same cycle wins)
//   o_tx_bits[7:0]     config word, held from o_tx_dv until the next frame
//   o_tx_dv            one-cycle frame start pulse
//   i_rx_dv, i_rx_data receiver result strobe and 12-bit data
//   o_sample_dv/ch/data published sample, paired with its channel
//   o_scan_done        with o_sample_dv when the channel is the highest enabled one
//   o_busy             state is not IDLE
//   o_timeout_err      sticky receiver timeout flag
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | stopped; starts when enabled with a non-empty mask
// ISSUE       | frame start cycle, o_tx_dv high, frame counter at 0
// WAIT_RX     | waiting for the receiver result or the timeout
// PERIOD_WAIT | waiting for the sample period to expire
module adc_scan_scheduler #(
    parameter int SAMPLE_PERIOD = 5000,
    parameter int TIMEOUT       = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [7:0]  i_ch_mask,
    input  logic        i_uni,
    input  logic        i_err_clr,
    output logic [7:0]  o_tx_bits,
    output logic        o_tx_dv,
    input  logic        i_rx_dv,
    input  logic [11:0] i_rx_data,
    output logic        o_sample_dv,
    output logic [2:0]  o_sample_ch,
    output logic [11:0] o_sample_data,
    output logic        o_scan_done,
    output logic        o_busy,
    output logic        o_timeout_err
);

    localparam int CW = $clog2(SAMPLE_PERIOD);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_ISSUE       = 2'd1;
    localparam logic [1:0] ST_WAIT_RX     = 2'd2;
    localparam logic [1:0] ST_PERIOD_WAIT = 2'd3;

    logic [1:0]    state;
    logic [2:0]    cur_ch;
    logic [2:0]    sent_last;
    logic [2:0]    sent_prev;
    logic          prime;
    logic [CW-1:0] frame_cnt;

    logic [2:0]    sel_ch;
    logic          start_ok;
    logic          period_end;
    logic          timeout_hit;
    logic          go_issue;

    function automatic logic [2:0] lowest_ch(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = i[2:0];
        end
        return r;
    endfunction

    function automatic logic [2:0] highest_ch(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r = i[2:0];
        end
        return r;
    endfunction

    // Next enabled channel strictly above c, wrapping to the lowest enabled one.
    function automatic logic [2:0] next_ch(input logic [2:0] c, input logic [7:0] m);
        logic [2:0] r;
        r = lowest_ch(m);
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(c))) r = i[2:0];
        end
        return r;
    endfunction

    function automatic logic [7:0] cfg_word(input logic [2:0] ch, input logic uni);
        return {1'b1, ch[0], ch[2:1], uni, 1'b0, 2'b00};
    endfunction

    // One counter serves both the period and the timeout: both restart at ISSUE.
    always_comb begin
        start_ok    = i_enable && (i_ch_mask != 8'h00);
        period_end  = (state == ST_PERIOD_WAIT) && (frame_cnt == CW'(SAMPLE_PERIOD - 1));
        timeout_hit = (state == ST_WAIT_RX) && !i_rx_dv && (frame_cnt == CW'(TIMEOUT - 1));
        go_issue    = start_ok && ((state == ST_IDLE) || period_end);
        // A channel disabled since it was queued is skipped before it is sent.
        if (state == ST_IDLE) begin
            sel_ch = lowest_ch(i_ch_mask);
        end else if (i_ch_mask[cur_ch]) begin
            sel_ch = cur_ch;
        end else begin
            sel_ch = next_ch(cur_ch, i_ch_mask);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            cur_ch        <= 3'd0;
            sent_last     <= 3'd0;
            sent_prev     <= 3'd0;
            prime         <= 1'b0;
            frame_cnt     <= '0;
            o_tx_bits     <= 8'h00;
            o_sample_dv   <= 1'b0;
            o_sample_ch   <= 3'd0;
            o_sample_data <= 12'h000;
            o_scan_done   <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_sample_dv <= 1'b0;
            o_scan_done <= 1'b0;

            if (state != ST_IDLE) frame_cnt <= frame_cnt + 1'b1;

            if (i_err_clr) o_timeout_err <= 1'b0;

            case (state)
                ST_ISSUE: state <= ST_WAIT_RX;
                ST_WAIT_RX: begin
                    if (i_rx_dv) begin
                        // Data in this frame answers the config sent one frame earlier.
                        if (prime) begin
                            o_sample_dv   <= 1'b1;
                            o_sample_ch   <= sent_prev;
                            o_sample_data <= i_rx_data;
                            o_scan_done   <= (sent_prev == highest_ch(i_ch_mask));
                        end
                        prime <= 1'b1;
                        state <= ST_PERIOD_WAIT;
                    end else if (timeout_hit) begin
                        o_timeout_err <= 1'b1;
                        prime         <= 1'b0;
                        state         <= ST_PERIOD_WAIT;
                    end
                end
                ST_PERIOD_WAIT: begin
                    if (period_end && !start_ok) begin
                        state <= ST_IDLE;
                        prime <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (go_issue) begin
                state     <= ST_ISSUE;
                frame_cnt <= '0;
                o_tx_bits <= cfg_word(sel_ch, i_uni);
                sent_prev <= sent_last;
                sent_last <= sel_ch;
                cur_ch    <= next_ch(sel_ch, i_ch_mask);
            end
        end
    end

    assign o_tx_dv = (state == ST_ISSUE);
    assign o_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_adc_scan_scheduler.sv
module tb_adc_scan_scheduler;

    localparam int SP = 5000;
    localparam int TO = 4096;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_enable;
    logic [7:0]  i_ch_mask;
    logic        i_uni;
    logic        i_err_clr;
    logic [7:0]  o_tx_bits;
    logic        o_tx_dv;
    logic        i_rx_dv;
    logic [11:0] i_rx_data;
    logic        o_sample_dv;
    logic [2:0]  o_sample_ch;
    logic [11:0] o_sample_data;
    logic        o_scan_done;
    logic        o_busy;
    logic        o_timeout_err;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int last_tx  = 0;

    adc_scan_scheduler #(.SAMPLE_PERIOD(SP), .TIMEOUT(TO)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_enable     (i_enable),
        .i_ch_mask    (i_ch_mask),
        .i_uni        (i_uni),
        .i_err_clr    (i_err_clr),
        .o_tx_bits    (o_tx_bits),
        .o_tx_dv      (o_tx_dv),
        .i_rx_dv      (i_rx_dv),
        .i_rx_data    (i_rx_data),
        .o_sample_dv  (o_sample_dv),
        .o_sample_ch  (o_sample_ch),
        .o_sample_data(o_sample_data),
        .o_scan_done  (o_scan_done),
        .o_busy       (o_busy),
        .o_timeout_err(o_timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp_bits, input bit chk_gap);
        int n;
        n = 0;
        while (o_tx_dv !== 1'b1 && n < SP + 1000) begin
            tick(1);
            n++;
        end
        check({tag, "_txdv"}, 32'(o_tx_dv), 32'h1);
        check({tag, "_bits"}, 32'(o_tx_bits), 32'(exp_bits));
        check({tag, "_busy"}, 32'(o_busy), 32'h1);
        if (chk_gap) check({tag, "_gap"}, 32'(cycle - last_tx), 32'(SP));
        last_tx = cycle;
    endtask

    task automatic rx(input string tag, input int d, input logic [11:0] data,
                      input bit exp_dv, input logic [2:0] exp_ch, input bit exp_done);
        tick(d);
        i_rx_dv   = 1'b1;
        i_rx_data = data;
        tick(1);
        i_rx_dv   = 1'b0;
        check({tag, "_sdv"}, 32'(o_sample_dv), 32'(exp_dv));
        if (exp_dv) begin
            check({tag, "_sch"}, 32'(o_sample_ch), 32'(exp_ch));
            check({tag, "_sdata"}, 32'(o_sample_data), 32'(data));
            check({tag, "_done"}, 32'(o_scan_done), 32'(exp_done));
        end
        tick(1);
        check({tag, "_sdv_pulse"}, 32'(o_sample_dv), 32'h0);
    endtask

    initial begin
        int seen;
        i_rst     = 1'b1;
        i_enable  = 1'b0;
        i_ch_mask = 8'h00;
        i_uni     = 1'b0;
        i_err_clr = 1'b0;
        i_rx_dv   = 1'b0;
        i_rx_data = 12'h000;
        tick(3);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_txdv", 32'(o_tx_dv), 32'h0);
        check("rst_bits", 32'(o_tx_bits), 32'h0);
        check("rst_sdv", 32'(o_sample_dv), 32'h0);
        check("rst_err", 32'(o_timeout_err), 32'h0);

        // Scan of channels 0 and 2, unipolar.
        i_ch_mask = 8'h05;
        i_uni     = 1'b1;
        i_enable  = 1'b1;
        i_rst     = 1'b0;
        wait_tx("f1", 8'h88, 1'b0);
        rx("f1", 100, 12'h111, 1'b0, 3'd0, 1'b0);
        wait_tx("f2", 8'h98, 1'b1);
        rx("f2", 50, 12'habc, 1'b1, 3'd0, 1'b0);
        // Strobe outside WAIT_RX must be ignored.
        i_rx_dv   = 1'b1;
        i_rx_data = 12'hfff;
        tick(1);
        i_rx_dv = 1'b0;
        tick(1);
        check("stray_rx_sdv", 32'(o_sample_dv), 32'h0);
        wait_tx("f3", 8'h88, 1'b1);
        rx("f3", 200, 12'h5a5, 1'b1, 3'd2, 1'b1);

        // Timeout, with a clear request colliding with the timeout cycle.
        wait_tx("f4", 8'h98, 1'b1);
        tick(TO - 1);
        check("to_before", 32'(o_timeout_err), 32'h0);
        i_err_clr = 1'b1;
        tick(1);
        i_err_clr = 1'b0;
        check("to_set", 32'(o_timeout_err), 32'h1);
        tick(1);
        check("to_sticky", 32'(o_timeout_err), 32'h1);
        wait_tx("f5", 8'h88, 1'b1);
        rx("f5", 100, 12'h777, 1'b0, 3'd0, 1'b0);
        i_err_clr = 1'b1;
        tick(1);
        i_err_clr = 1'b0;
        check("err_clr", 32'(o_timeout_err), 32'h0);
        wait_tx("f6", 8'h98, 1'b1);
        rx("f6", 100, 12'h234, 1'b1, 3'd0, 1'b0);

        // Mask edits mid-scan.
        i_ch_mask = 8'h01;
        wait_tx("f7", 8'h88, 1'b1);
        rx("f7", 100, 12'h321, 1'b1, 3'd2, 1'b0);
        i_ch_mask = 8'h80;
        wait_tx("f8", 8'hf8, 1'b1);

        // Enable dropped mid-frame: sample still published, then idle.
        tick(10);
        i_enable = 1'b0;
        rx("f8", 90, 12'h0f0, 1'b1, 3'd0, 1'b0);
        while (cycle < last_tx + SP - 1) tick(1);
        check("stop_busy_last", 32'(o_busy), 32'h1);
        tick(1);
        check("stop_busy_idle", 32'(o_busy), 32'h0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (o_tx_dv === 1'b1) seen++;
        end
        check("stop_no_tx", 32'(seen), 32'h0);

        // Asynchronous reset during WAIT_RX.
        i_ch_mask = 8'h03;
        i_enable  = 1'b1;
        wait_tx("fa", 8'h88, 1'b0);
        rx("fa", 20, 12'h456, 1'b0, 3'd0, 1'b0);
        wait_tx("fb", 8'hc8, 1'b1);
        tick(10);
        i_rst = 1'b1;
        #1;
        check("arst_busy", 32'(o_busy), 32'h0);
        check("arst_txdv", 32'(o_tx_dv), 32'h0);
        check("arst_bits", 32'(o_tx_bits), 32'h0);
        check("arst_sdv", 32'(o_sample_dv), 32'h0);
        check("arst_sch", 32'(o_sample_ch), 32'h0);
        check("arst_sdata", 32'(o_sample_data), 32'h0);
        tick(3);
        i_rst = 1'b0;
        wait_tx("fd", 8'h88, 1'b0);
        rx("fd", 30, 12'h999, 1'b0, 3'd0, 1'b0);
        wait_tx("fe", 8'hc8, 1'b1);
        rx("fe", 30, 12'h8e1, 1'b1, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
